// File: rtl/pgm_vram_arbiter.sv
// Video RAM arbiter: one single-port RAM shared by line fetch, sprite fetch and the 68k CPU.
// Fixed priority during active display, round-robin in blanking, with a CPU starvation guard.
module pgm_vram_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int RD_LAT       = 2,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_active,
  input  logic          lf_req,
  input  logic [AW-1:0] lf_addr,
  output logic          lf_gnt,
  output logic          lf_rvalid,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_gnt,
  output logic          spr_rvalid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {RR_LF = 2'd0, RR_SPR = 2'd1, RR_CPU = 2'd2} rr_e;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_LF = 2'd1, TAG_SPR = 2'd2, TAG_CPU = 2'd3} tag_e;

  localparam logic [7:0] MAX_WAIT = 8'(CPU_MAX_WAIT);

  rr_e           rr_q, rr_d;
  logic [7:0]    starve_q, starve_d;
  logic          lf_gnt_q, lf_gnt_d;
  logic          spr_gnt_q, spr_gnt_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  tag_e          tag_q [RD_LAT];
  tag_e          tag_d [RD_LAT];
  logic          lf_rvalid_q, lf_rvalid_d;
  logic          spr_rvalid_q, spr_rvalid_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic lf_elig, spr_elig, cpu_elig, cpu_force;
  logic win_lf, win_spr, win_cpu;
  tag_e tag_in, tag_out;

  // A requester whose grant pulse is showing this cycle sits out one decision.
  always_comb begin
    lf_elig   = lf_req  & ~lf_gnt_q;
    spr_elig  = spr_req & ~spr_gnt_q;
    cpu_elig  = cpu_req & ~cpu_gnt_q;
    cpu_force = cpu_elig && (starve_q >= MAX_WAIT);
    win_lf    = 1'b0;
    win_spr   = 1'b0;
    win_cpu   = 1'b0;
    if (cpu_force) begin
      win_cpu = 1'b1;
    end else if (vid_active) begin
      if (lf_elig)       win_lf  = 1'b1;
      else if (spr_elig) win_spr = 1'b1;
      else if (cpu_elig) win_cpu = 1'b1;
    end else begin
      case (rr_q)
        RR_SPR: begin
          if (spr_elig)      win_spr = 1'b1;
          else if (cpu_elig) win_cpu = 1'b1;
          else if (lf_elig)  win_lf  = 1'b1;
        end
        RR_CPU: begin
          if (cpu_elig)      win_cpu = 1'b1;
          else if (lf_elig)  win_lf  = 1'b1;
          else if (spr_elig) win_spr = 1'b1;
        end
        default: begin
          if (lf_elig)       win_lf  = 1'b1;
          else if (spr_elig) win_spr = 1'b1;
          else if (cpu_elig) win_cpu = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (!vid_active) begin
      if (win_lf)       rr_d = RR_SPR;
      else if (win_spr) rr_d = RR_CPU;
      else if (win_cpu) rr_d = RR_LF;
    end

    starve_d = starve_q;
    if (!cpu_req || cpu_gnt_q || win_cpu) starve_d = '0;
    else if (starve_q != 8'hFF)           starve_d = starve_q + 8'd1;

    lf_gnt_d  = win_lf;
    spr_gnt_d = win_spr;
    cpu_gnt_d = win_cpu;
    mem_en_d  = win_lf | win_spr | win_cpu;
    mem_we_d  = win_cpu & cpu_we;

    mem_addr_d = mem_addr_q;
    if (win_lf)       mem_addr_d = lf_addr;
    else if (win_spr) mem_addr_d = spr_addr;
    else if (win_cpu) mem_addr_d = cpu_addr;

    mem_wdata_d = mem_we_d ? cpu_wdata : mem_wdata_q;
  end

  // Tag of the read issued this cycle travels alongside the RAM latency.
  always_comb begin
    tag_in = TAG_NONE;
    if (mem_en_q && !mem_we_q) begin
      if (lf_gnt_q)       tag_in = TAG_LF;
      else if (spr_gnt_q) tag_in = TAG_SPR;
      else                tag_in = TAG_CPU;
    end
    tag_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

    tag_out      = tag_q[RD_LAT-1];
    lf_rvalid_d  = (tag_out == TAG_LF);
    spr_rvalid_d = (tag_out == TAG_SPR);
    cpu_rvalid_d = (tag_out == TAG_CPU);
    rdata_d      = (tag_out != TAG_NONE) ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q         <= RR_LF;
      starve_q     <= '0;
      lf_gnt_q     <= 1'b0;
      spr_gnt_q    <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= TAG_NONE;
      lf_rvalid_q  <= 1'b0;
      spr_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rr_q         <= rr_d;
      starve_q     <= starve_d;
      lf_gnt_q     <= lf_gnt_d;
      spr_gnt_q    <= spr_gnt_d;
      cpu_gnt_q    <= cpu_gnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
      lf_rvalid_q  <= lf_rvalid_d;
      spr_rvalid_q <= spr_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign lf_gnt     = lf_gnt_q;
  assign spr_gnt    = spr_gnt_q;
  assign cpu_gnt    = cpu_gnt_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign lf_rvalid  = lf_rvalid_q;
  assign spr_rvalid = spr_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign rdata      = rdata_q;

endmodule
